// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: word width, fetch FSM encoding, address-source select, reset/NOP defaults.
// Latency: none (types, constants and a pure helper function only).
// Backpressure: not applicable.
package pipeline_pkg;

    localparam int WORD_W = 32;

    localparam logic [WORD_W-1:0] DEFAULT_RESET_PC  = 32'h0000_0000;
    localparam logic [WORD_W-1:0] DEFAULT_NOP_INSTR = 32'h0000_0000;  // sll $0,$0,0

    // REQ  : request for pc outstanding
    // DROP : a request for a superseded address is still in flight
    // FULL : bufWord holds the word for pc, no request outstanding
    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_DROP = 2'd1,
        ST_FULL = 2'd2
    } fetchState_e;

    // Next-value source for the pc / reqAddr registers.
    typedef enum logic [1:0] {
        SRC_INC = 2'd0,   // pc + 4
        SRC_TGT = 2'd1,   // redirect target
        SRC_PC  = 2'd2    // current pc (re-issue after a dropped fetch)
    } addrSrc_e;

    // Instructions are word aligned; low two address bits are discarded.
    function automatic logic [WORD_W-1:0] alignWord(input logic [WORD_W-1:0] a);
        return {a[WORD_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_pc_unit.sv
// PC datapath: pc/reqAddr registers, redirect target select and alignment, pc+4 adder.
// Latency: pc/reqAddr update on the posedge after their write enable; redirect/target/pcInc are combinational.
// Backpressure: none locally; the fetch FSM decides when each register is written.
// Ports: clk, rst | pcWe/pcSrc, reqWe/reqSrc from the FSM | branch/jump redirect inputs |
//        redirect (branchTaken|jump), pc, reqAddr, pcInc (pc+4, wraps mod 2^32).
module if_pc_unit
    import pipeline_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pcWe,
    input  addrSrc_e          pcSrc,
    input  logic              reqWe,
    input  addrSrc_e          reqSrc,
    input  logic              branchTaken,
    input  logic [WORD_W-1:0] branchTarget,
    input  logic              jump,
    input  logic [WORD_W-1:0] jumpTarget,
    output logic              redirect,
    output logic [WORD_W-1:0] pc,
    output logic [WORD_W-1:0] reqAddr,
    output logic [WORD_W-1:0] pcInc
);

    logic [WORD_W-1:0] target;
    logic [WORD_W-1:0] pcNext;
    logic [WORD_W-1:0] reqNext;

    // Branch outranks jump when ID asserts both.
    assign redirect = branchTaken | jump;
    assign target   = alignWord(branchTaken ? branchTarget : jumpTarget);
    assign pcInc    = pc + 32'd4;

    function automatic logic [WORD_W-1:0] pickAddr(
        input addrSrc_e          src,
        input logic [WORD_W-1:0] incVal,
        input logic [WORD_W-1:0] tgtVal,
        input logic [WORD_W-1:0] pcVal
    );
        case (src)
            SRC_TGT: return tgtVal;
            SRC_PC:  return pcVal;
            default: return incVal;
        endcase
    endfunction

    assign pcNext  = pickAddr(pcSrc,  pcInc, target, pc);
    assign reqNext = pickAddr(reqSrc, pcInc, target, pc);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc      <= RESET_PC;
            reqAddr <= RESET_PC;
        end else begin
            if (pcWe)  pc      <= pcNext;
            if (reqWe) reqAddr <= reqNext;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch: owns PC, issues req/ack imem fetches, buffers one word, applies ID redirects, drives IF/ID.
// Latency: instruction appears one cycle after imemAck when pcWr=1 (one instruction per cycle with zero-wait memory).
// Backpressure: pcWr=0 freezes outputs; a word acked during a stall is held in bufWord and imemReq drops until it issues.
// Ports: clk, rst | pcWr, branchTaken/branchTarget, jump/jumpTarget | imemReq/imemAddr out, imemAck/imemData in |
//        instruction, pcPlus4, instrValid registered toward IF/ID (bubble = NOP_INSTR, instrValid=0).
module if_fetch_stage
    import pipeline_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [WORD_W-1:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pcWr,
    input  logic              branchTaken,
    input  logic [WORD_W-1:0] branchTarget,
    input  logic              jump,
    input  logic [WORD_W-1:0] jumpTarget,
    output logic              imemReq,
    output logic [WORD_W-1:0] imemAddr,
    input  logic              imemAck,
    input  logic [WORD_W-1:0] imemData,
    output logic [WORD_W-1:0] instruction,
    output logic [WORD_W-1:0] pcPlus4,
    output logic              instrValid
);

    fetchState_e       state;
    logic [WORD_W-1:0] bufWord;

    logic              redirect;
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] reqAddr;
    logic [WORD_W-1:0] pcInc;

    logic              pcWe;
    logic              reqWe;
    addrSrc_e          pcSrc;
    addrSrc_e          reqSrc;

    // A request is outstanding in REQ and DROP; acks seen in FULL are spurious.
    logic reqActive;
    logic ackEff;
    assign reqActive = (state == ST_REQ) || (state == ST_DROP);
    assign ackEff    = imemAck && reqActive;

    assign imemReq  = reqActive && !rst;
    assign imemAddr = reqAddr;

    if_pc_unit #(
        .RESET_PC(RESET_PC)
    ) u_pcUnit (
        .clk         (clk),
        .rst         (rst),
        .pcWe        (pcWe),
        .pcSrc       (pcSrc),
        .reqWe       (reqWe),
        .reqSrc      (reqSrc),
        .branchTaken (branchTaken),
        .branchTarget(branchTarget),
        .jump        (jump),
        .jumpTarget  (jumpTarget),
        .redirect    (redirect),
        .pc          (pc),
        .reqAddr     (reqAddr),
        .pcInc       (pcInc)
    );

    // Address register control. reqAddr only moves when no request is in
    // flight afterwards for the old address, which keeps imemAddr stable
    // for the whole req..ack window.
    always_comb begin
        pcWe   = 1'b0;
        reqWe  = 1'b0;
        pcSrc  = SRC_INC;
        reqSrc = SRC_INC;
        case (state)
            ST_REQ: begin
                if (redirect) begin
                    pcWe  = 1'b1;
                    pcSrc = SRC_TGT;
                    if (ackEff) begin
                        reqWe  = 1'b1;
                        reqSrc = SRC_TGT;
                    end
                end else if (ackEff && pcWr) begin
                    pcWe  = 1'b1;
                    reqWe = 1'b1;
                end
            end
            ST_DROP: begin
                if (redirect) begin
                    pcWe  = 1'b1;
                    pcSrc = SRC_TGT;
                end
                // Stale word is back: re-aim at the newest pc, including a
                // redirect arriving in this very cycle.
                if (ackEff) begin
                    reqWe  = 1'b1;
                    reqSrc = redirect ? SRC_TGT : SRC_PC;
                end
            end
            ST_FULL: begin
                if (redirect) begin
                    pcWe   = 1'b1;
                    reqWe  = 1'b1;
                    pcSrc  = SRC_TGT;
                    reqSrc = SRC_TGT;
                end else if (pcWr) begin
                    pcWe  = 1'b1;
                    reqWe = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_REQ;
            bufWord     <= '0;
            instruction <= NOP_INSTR;
            pcPlus4     <= '0;
            instrValid  <= 1'b0;
        end else begin
            case (state)
                ST_REQ: begin
                    if (ackEff && redirect) begin
                        instruction <= NOP_INSTR;
                        instrValid  <= 1'b0;
                    end else if (ackEff && pcWr) begin
                        instruction <= imemData;
                        pcPlus4     <= pcInc;
                        instrValid  <= 1'b1;
                    end else if (ackEff) begin
                        bufWord <= imemData;
                        state   <= ST_FULL;
                    end else if (redirect) begin
                        instruction <= NOP_INSTR;
                        instrValid  <= 1'b0;
                        state       <= ST_DROP;
                    end else if (pcWr) begin
                        instruction <= NOP_INSTR;
                        instrValid  <= 1'b0;
                    end
                end
                ST_DROP: begin
                    if (redirect || pcWr) begin
                        instruction <= NOP_INSTR;
                        instrValid  <= 1'b0;
                    end
                    if (ackEff) state <= ST_REQ;
                end
                ST_FULL: begin
                    if (redirect) begin
                        instruction <= NOP_INSTR;
                        instrValid  <= 1'b0;
                        state       <= ST_REQ;
                    end else if (pcWr) begin
                        instruction <= bufWord;
                        pcPlus4     <= pcInc;
                        instrValid  <= 1'b1;
                        state       <= ST_REQ;
                    end
                end
                default: state <= ST_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios then randomized redirects/stalls/memory latency.
// Latency: one bench cycle per clock; inputs driven and outputs compared on the negedge.
// Backpressure: memory model acks after a programmable wait count; pcWr randomized.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst, pcWr, branchTaken, jump, imemAck;
    logic [31:0] branchTarget, jumpTarget, imemData;
    logic        imemReq, instrValid;
    logic [31:0] imemAddr, instruction, pcPlus4;

    always #5 clk = ~clk;

    if_fetch_stage dut (
        .clk         (clk),
        .rst         (rst),
        .pcWr        (pcWr),
        .branchTaken (branchTaken),
        .branchTarget(branchTarget),
        .jump        (jump),
        .jumpTarget  (jumpTarget),
        .imemReq     (imemReq),
        .imemAddr    (imemAddr),
        .imemAck     (imemAck),
        .imemData    (imemData),
        .instruction (instruction),
        .pcPlus4     (pcPlus4),
        .instrValid  (instrValid)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: what the fetch stage must look like after each edge.
    logic [31:0] mPc, mReq, mBuf, mInstr, mPp4;
    bit          mOut;     // a request is outstanding
    bit          mStale;   // the outstanding request is for an abandoned address
    bit          mBufV;    // a fetched word is parked waiting for pcWr
    bit          mValid;
    bit          mRst;     // rst currently applied to the DUT

    // Memory model
    int memLat      = 0;
    int waitCnt     = 0;
    int ackOverride = -1;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a * 32'h9E37_79B1) + 32'h0BAD_F00D;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic modelStep(input bit r, input bit pw, input bit br, input logic [31:0] bt,
                             input bit j, input logic [31:0] jt, input bit ack, input logic [31:0] data);
        bit          redir, bubble, issue, ackE;
        logic [31:0] tgt, w;
        redir  = br || j;
        tgt    = (br ? bt : jt) & 32'hFFFF_FFFC;
        bubble = 0;
        issue  = 0;
        w      = '0;
        ackE   = ack && mOut;
        if (r) begin
            mPc = 32'h0; mReq = 32'h0; mOut = 1; mStale = 0; mBufV = 0;
            mInstr = 32'h0; mPp4 = 32'h0; mValid = 0;
            return;
        end
        if (mOut && !mStale) begin
            if (ackE) begin
                if (redir)   begin mPc = tgt; mReq = tgt; bubble = 1; end
                else if (pw) begin issue = 1; w = data; end
                else         begin mBufV = 1; mBuf = data; mOut = 0; end
            end else if (redir) begin
                mPc = tgt; mStale = 1; bubble = 1;
            end else if (pw) begin
                bubble = 1;
            end
        end else if (mOut) begin
            if (redir) mPc = tgt;
            if (redir || pw) bubble = 1;
            if (ackE) begin mStale = 0; mReq = mPc; end
        end else begin
            if (redir)   begin mBufV = 0; mPc = tgt; mReq = tgt; mOut = 1; bubble = 1; end
            else if (pw) begin mBufV = 0; mOut = 1; issue = 1; w = mBuf; end
        end
        if (issue) begin
            mInstr = w; mPp4 = mPc + 32'd4; mValid = 1;
            mPc = mPc + 32'd4; mReq = mPc;
        end
        if (bubble) begin
            mInstr = 32'h0; mValid = 0;
        end
    endtask

    task automatic compareAll();
        bit reqExp;
        reqExp = mOut && !mRst;
        chk("imemReq", {31'b0, imemReq}, {31'b0, reqExp});
        if (reqExp) chk("imemAddr", imemAddr, mReq);
        chk("instrValid", {31'b0, instrValid}, {31'b0, mValid});
        chk("instruction", instruction, mInstr);
        chk("pcPlus4", pcPlus4, mPp4);
        // A valid word must always be the memory word at its own address.
        if (mValid) chk("wordMatchesAddr", instruction, memWord(mPp4 - 32'd4));
    endtask

    task automatic doCycle(input bit r, input bit pw, input bit br, input logic [31:0] bt,
                           input bit j, input logic [31:0] jt);
        bit a;
        compareAll();
        rst = r; pcWr = pw; branchTaken = br; branchTarget = bt; jump = j; jumpTarget = jt;
        a = 0;
        if (mOut && !r) begin
            if (waitCnt >= memLat) begin a = 1; waitCnt = 0; end
            else waitCnt++;
        end else begin
            waitCnt = 0;
        end
        if (ackOverride >= 0) a = ackOverride[0];
        imemAck  = a;
        imemData = a ? memWord(mReq) : $urandom();
        modelStep(r, pw, br, bt, j, jt, a, imemData);
        mRst = r;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1; pcWr = 0; branchTaken = 0; jump = 0; imemAck = 0;
        branchTarget = '0; jumpTarget = '0; imemData = '0;
        modelStep(1, 0, 0, 0, 0, 0, 0, 0);
        mRst = 1;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_imemReq", {31'b0, imemReq}, 32'h0);
        chk("rst_instrValid", {31'b0, instrValid}, 32'h0);
        chk("rst_pcPlus4", pcPlus4, 32'h0);
        chk("rst_instruction", instruction, 32'h0);

        // Zero-wait memory, sequential fetch
        doCycle(0, 1, 0, 0, 0, 0);
        chk("seq_pcPlus4_4", pcPlus4, 32'h4);
        chk("seq_addr_4", imemAddr, 32'h4);
        chk("seq_instr0", instruction, memWord(32'h0));
        doCycle(0, 1, 0, 0, 0, 0);
        chk("seq_pcPlus4_8", pcPlus4, 32'h8);
        chk("seq_addr_8", imemAddr, 32'h8);

        // Stall at pc=8 with the word acked: buffered, request dropped
        repeat (3) doCycle(0, 0, 0, 0, 0, 0);
        chk("stall_req_low", {31'b0, imemReq}, 32'h0);
        chk("stall_pcPlus4_frozen", pcPlus4, 32'h8);
        chk("stall_instr_frozen", instruction, memWord(32'h4));
        doCycle(0, 1, 0, 0, 0, 0);
        chk("unstall_instr_buf", instruction, memWord(32'h8));
        chk("unstall_pcPlus4", pcPlus4, 32'hC);
        chk("unstall_addr", imemAddr, 32'hC);

        // Two wait-cycle memory, branch while waiting on 0x10
        memLat = 2;
        repeat (3) doCycle(0, 1, 0, 0, 0, 0);
        chk("lat_addr_10", imemAddr, 32'h10);
        doCycle(0, 1, 1, 32'h40, 0, 0);
        chk("br_addr_holds_a", imemAddr, 32'h10);
        chk("br_bubble", {31'b0, instrValid}, 32'h0);
        doCycle(0, 1, 0, 0, 0, 0);
        chk("br_addr_holds_b", imemAddr, 32'h10);
        doCycle(0, 1, 0, 0, 0, 0);
        chk("br_next_req", imemAddr, 32'h40);
        chk("br_stale_not_valid", {31'b0, instrValid}, 32'h0);
        repeat (3) doCycle(0, 1, 0, 0, 0, 0);
        chk("br_target_pcPlus4", pcPlus4, 32'h44);
        chk("br_target_instr", instruction, memWord(32'h40));

        // Branch beats jump; target alignment
        memLat = 0;
        doCycle(0, 1, 1, 32'h80, 1, 32'h100);
        chk("prio_addr", imemAddr, 32'h80);
        chk("prio_bubble", {31'b0, instrValid}, 32'h0);
        doCycle(0, 1, 1, 32'h83, 0, 0);
        chk("align_addr", imemAddr, 32'h80);
        doCycle(0, 1, 0, 0, 0, 0);
        chk("align_pcPlus4", pcPlus4, 32'h84);

        // PC wrap
        doCycle(0, 1, 0, 0, 1, 32'hFFFF_FFFC);
        chk("wrap_addr", imemAddr, 32'hFFFF_FFFC);
        doCycle(0, 1, 0, 0, 0, 0);
        chk("wrap_pcPlus4", pcPlus4, 32'h0);
        chk("wrap_next_addr", imemAddr, 32'h0);
        chk("wrap_instr", instruction, memWord(32'hFFFF_FFFC));

        // Reset while a stale request is in flight; its ack must be ignored
        memLat = 3;
        doCycle(0, 1, 0, 0, 0, 0);
        doCycle(0, 1, 1, 32'h200, 0, 0);
        ackOverride = 1;
        doCycle(1, 0, 0, 0, 0, 0);
        ackOverride = -1;
        chk("drop_rst_valid", {31'b0, instrValid}, 32'h0);
        chk("drop_rst_addr", imemAddr, 32'h0);
        repeat (4) doCycle(0, 1, 0, 0, 0, 0);
        chk("drop_rst_refetch_pcPlus4", pcPlus4, 32'h4);
        chk("drop_rst_refetch_instr", instruction, memWord(32'h0));

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit          r, pw, br, j;
            logic [31:0] bt, jt;
            if ($urandom_range(0, 49) == 0) memLat = $urandom_range(0, 3);
            r  = ($urandom_range(0, 99) == 0);
            pw = ($urandom_range(0, 9) < 7);
            br = ($urandom_range(0, 9) == 0);
            j  = ($urandom_range(0, 9) == 0);
            bt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15) : $urandom();
            jt = $urandom();
            doCycle(r, pw, br, bt, j, jt);
        end
        compareAll();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
